// File: rtl/enc_chan_sched_if.sv
// Signal bundle between the ADPCM channel scheduler and its neighbours.
// Latency: none (wires only).
// Backpressure: none here; the datapath stalls the scheduler through enc_done.
//
// Groups:
//   framing      : fsync, ch_en, clr_err (in); busy, overrun, wdog_err (out)
//   sample buffer: pcm_rd, pcm_ch (out); pcm_in (in)
//   datapath     : enc_start, enc_ch, enc_pcm (out); enc_done, enc_code (in)
//   code buffer  : code_wr, code_ch, code (out)
// The master modport is the scheduler side. The slave modport is the environment side.
interface enc_chan_sched_if #(
    parameter int NCH = 32,
    parameter int CHW = 5
);
    logic           fsync;
    logic [NCH-1:0] ch_en;
    logic           clr_err;
    logic           pcm_rd;
    logic [CHW-1:0] pcm_ch;
    logic [7:0]     pcm_in;
    logic           enc_start;
    logic [CHW-1:0] enc_ch;
    logic [7:0]     enc_pcm;
    logic           enc_done;
    logic [3:0]     enc_code;
    logic           code_wr;
    logic [CHW-1:0] code_ch;
    logic [3:0]     code;
    logic           busy;
    logic           overrun;
    logic           wdog_err;

    modport master (
        input  fsync, ch_en, clr_err, pcm_in, enc_done, enc_code,
        output pcm_rd, pcm_ch, enc_start, enc_ch, enc_pcm,
               code_wr, code_ch, code, busy, overrun, wdog_err
    );

    modport slave (
        output fsync, ch_en, clr_err, pcm_in, enc_done, enc_code,
        input  pcm_rd, pcm_ch, enc_start, enc_ch, enc_pcm,
               code_wr, code_ch, code, busy, overrun, wdog_err
    );
endinterface

// File: rtl/enc_chan_sched.sv
// Per-frame channel scheduler: reads a sample, runs the shared encoder and stores the code for each enabled channel.
// Latency: fsync -> pcm_rd in 1 cycle and -> enc_start in 3 cycles; enc_done -> code_wr in 1 cycle; at least 5 cycles per channel.
// Backpressure: waits in WAIT for enc_done; an fsync that arrives while busy is dropped and flagged as overrun.
//
// Ports: clk and reset (async, active-high), plus bus (enc_chan_sched_if.master).
//   The bus carries the framing inputs, the sample-buffer read port, the datapath launch/done handshake,
//   the code-buffer write port, and the busy/overrun/wdog_err status outputs.
// Option: define ENC_SCHED_WDOG_EN to build a WAIT-state watchdog of WDOG_CYC cycles.
//   When it fires, the block stores code 0 and sets the sticky wdog_err.
//   Without the macro, wdog_err is tied low.
module enc_chan_sched #(
    parameter int NCH      = 32,
    parameter int CHW      = 5,
    parameter int WDOG_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    enc_chan_sched_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CAPT  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] STORE = 3'd5;

    logic [2:0]     state;
    logic [NCH-1:0] frame_mask;  // channels of this frame that are not yet stored
    logic [NCH-1:0] rest_mask;
    logic [CHW-1:0] cur_ch;
    logic           pcm_rd_q;
    logic           enc_start_q;
    logic           code_wr_q;
    logic [7:0]     enc_pcm_q;
    logic [3:0]     code_q;
    logic           overrun_q;
    logic           wdog_err_q;
    logic           wdog_hit;
    logic           ovr_set;

    // Returns the lowest set bit. The search is bounded to 0..NCH-1, so the index cannot leave range.
    function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] m);
        lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest = CHW'(i);
        end
    endfunction

    // Drop the channel being stored. Whatever remains is strictly above cur_ch.
    assign rest_mask = frame_mask & ~(NCH'(1) << cur_ch);
    assign ovr_set   = bus.fsync && (state != IDLE);

`ifdef ENC_SCHED_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);
    logic [WDW-1:0] wdog_cnt;

    // The counter starts at 0 on the first WAIT edge. The watchdog fires on the WDOG_CYC-th WAIT edge without done.
    assign wdog_hit = (state == WAIT) && !bus.enc_done && (wdog_cnt == WDW'(WDOG_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              wdog_cnt <= '0;
        else if (state == WAIT) wdog_cnt <= wdog_cnt + 1'b1;
        else                    wdog_cnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            wdog_err_q <= 1'b0;
        else if (wdog_hit)    wdog_err_q <= 1'b1;
        else if (bus.clr_err) wdog_err_q <= 1'b0;
    end
`else
    assign wdog_hit   = 1'b0;
    assign wdog_err_q = 1'b0;
`endif

    // Sticky overrun flag. A set wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            overrun_q <= 1'b0;
        else if (ovr_set)     overrun_q <= 1'b1;
        else if (bus.clr_err) overrun_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            frame_mask  <= '0;
            cur_ch      <= '0;
            pcm_rd_q    <= 1'b0;
            enc_start_q <= 1'b0;
            code_wr_q   <= 1'b0;
            enc_pcm_q   <= '0;
            code_q      <= '0;
        end else begin
            pcm_rd_q    <= 1'b0;
            enc_start_q <= 1'b0;
            code_wr_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fsync && (|bus.ch_en)) begin
                        frame_mask <= bus.ch_en;
                        cur_ch     <= lowest(bus.ch_en);
                        pcm_rd_q   <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: state <= CAPT;
                CAPT: begin
                    enc_pcm_q   <= bus.pcm_in;
                    enc_start_q <= 1'b1;
                    state       <= START;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (bus.enc_done) begin
                        code_q    <= bus.enc_code;
                        code_wr_q <= 1'b1;
                        state     <= STORE;
                    end else if (wdog_hit) begin
                        code_q    <= 4'h0;
                        code_wr_q <= 1'b1;
                        state     <= STORE;
                    end
                end
                STORE: begin
                    frame_mask <= rest_mask;
                    if (|rest_mask) begin
                        cur_ch   <= lowest(rest_mask);
                        pcm_rd_q <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pcm_rd    = pcm_rd_q;
    assign bus.pcm_ch    = cur_ch;
    assign bus.enc_start = enc_start_q;
    assign bus.enc_ch    = cur_ch;
    assign bus.enc_pcm   = enc_pcm_q;
    assign bus.code_wr   = code_wr_q;
    assign bus.code_ch   = cur_ch;
    assign bus.code      = code_q;
    assign bus.busy      = (state != IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.wdog_err  = wdog_err_q;
endmodule

// File: tb/tb_enc_chan_sched.sv
// Randomized self-checking bench for enc_chan_sched, with a per-cycle schedule model and directed literal checks.
// Latency: n/a.
// Backpressure: the bench plays the datapath and chooses every enc_done delay itself.
module tb_enc_chan_sched;
    localparam int NCH  = 32;
    localparam int CHW  = 5;
    localparam int MAXC = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enc_chan_sched_if #(.NCH(NCH), .CHW(CHW)) bus();
    enc_chan_sched #(.NCH(NCH), .CHW(CHW), .WDOG_CYC(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Expected per-cycle outputs (index = cycle in which the value is visible) and planned datapath responses.
    bit             exp_rd[MAXC], exp_st[MAXC], exp_wr[MAXC], hold_v[MAXC];
    bit             pin_v[MAXC], done_v[MAXC], forbid[MAXC];
    logic [CHW-1:0] exp_ch[MAXC];
    logic [3:0]     exp_code[MAXC], done_code[MAXC];
    logic [7:0]     pin_val[MAXC], hold_val[MAXC];
    int busy_lo = 1, busy_hi = 0;
    bit exp_ovr = 1'b0;
    int cyc = 0, n_vec = 0, n_err = 0;
    int fix_d = 0, fix_s = -1, fix_c = -1;
    bit spur_en = 1'b0;
    int rd_cyc_q[$], wr_cyc_q[$], wr_ch_q[$], wr_code_q[$];
    int f, r;
    logic [31:0] m;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    // Turns one accepted frame into absolute-cycle expectations, using the documented timing.
    // rd at L, sample on pcm_in at L+1, start at L+2, done at L+2+d, write at L+3+d, next channel at L+4+d.
    task automatic plan_frame(input int fc, input logic [NCH-1:0] mk);
        int L, d, s, c;
        L = fc + 1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (mk[ch]) begin
                d = (fix_d > 0) ? fix_d : int'($urandom_range(1, 4));
                s = (fix_s >= 0) ? fix_s : int'($urandom_range(0, 255));
                c = (fix_c >= 0) ? fix_c : int'($urandom_range(0, 15));
                exp_rd[L] = 1'b1;        exp_ch[L] = CHW'(ch);
                pin_v[L+1] = 1'b1;       pin_val[L+1] = 8'(s);
                exp_st[L+2] = 1'b1;      exp_ch[L+2] = CHW'(ch);
                for (int k = L + 2; k <= L + 2 + d; k++) begin
                    hold_v[k] = 1'b1; hold_val[k] = 8'(s); forbid[k] = 1'b1;
                end
                done_v[L+2+d] = 1'b1;    done_code[L+2+d] = 4'(c);
                exp_wr[L+3+d] = 1'b1;    exp_ch[L+3+d] = CHW'(ch); exp_code[L+3+d] = 4'(c);
                L += 4 + d;
            end
        end
        if (mk != '0) begin
            busy_lo = fc + 1;
            busy_hi = L - 1;
        end
    endtask

    task automatic model_reset(input int rc);
        for (int k = rc; k < MAXC; k++) begin
            exp_rd[k] = 0; exp_st[k] = 0; exp_wr[k] = 0; hold_v[k] = 0;
            pin_v[k] = 0; done_v[k] = 0; forbid[k] = 0;
        end
        busy_lo = 1; busy_hi = 0; exp_ovr = 1'b0;
    endtask

    task automatic check(input int c);
        if (bus.pcm_rd === 1'b1) rd_cyc_q.push_back(c);
        if (bus.code_wr === 1'b1) begin
            wr_cyc_q.push_back(c); wr_ch_q.push_back(int'(bus.code_ch)); wr_code_q.push_back(int'(bus.code));
        end
        cmp("pcm_rd", 32'(bus.pcm_rd), 32'(exp_rd[c]));
        cmp("enc_start", 32'(bus.enc_start), 32'(exp_st[c]));
        cmp("code_wr", 32'(bus.code_wr), 32'(exp_wr[c]));
        cmp("busy", 32'(bus.busy), 32'(c >= busy_lo && c <= busy_hi));
        cmp("overrun", 32'(bus.overrun), 32'(exp_ovr));
        cmp("wdog_err", 32'(bus.wdog_err), 32'(0));
        if (exp_rd[c]) cmp("pcm_ch", 32'(bus.pcm_ch), 32'(exp_ch[c]));
        if (exp_st[c]) cmp("enc_ch", 32'(bus.enc_ch), 32'(exp_ch[c]));
        if (exp_wr[c]) begin
            cmp("code_ch", 32'(bus.code_ch), 32'(exp_ch[c]));
            cmp("code", 32'(bus.code), 32'(exp_code[c]));
        end
        if (hold_v[c]) cmp("enc_pcm", 32'(bus.enc_pcm), 32'(hold_val[c]));
        if (reset) begin
            cmp("rst_pcm_ch", 32'(bus.pcm_ch), 32'(0));
            cmp("rst_enc_ch", 32'(bus.enc_ch), 32'(0));
            cmp("rst_code_ch", 32'(bus.code_ch), 32'(0));
            cmp("rst_enc_pcm", 32'(bus.enc_pcm), 32'(0));
            cmp("rst_code", 32'(bus.code), 32'(0));
        end
    endtask

    // One clock: drive this cycle's inputs, compare the visible outputs, then advance the model.
    task automatic tick(input bit fs, input logic [31:0] mk, input bit clr, input bit rst_p);
        bit busy_now;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > MAXC - 300) begin
            n_err++;
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 300);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "cycle budget exhausted");
        end
        reset = rst_p;
        if (rst_p) model_reset(cyc);
        bus.fsync   = fs;
        bus.ch_en   = fs ? mk : $urandom;
        bus.clr_err = clr;
        bus.pcm_in  = pin_v[cyc] ? pin_val[cyc] : 8'($urandom);
        if (done_v[cyc]) begin
            bus.enc_done = 1'b1;
            bus.enc_code = done_code[cyc];
        end else begin
            bus.enc_done = spur_en && !forbid[cyc] && ($urandom_range(0, 3) == 0);
            bus.enc_code = 4'($urandom);
        end
        @(negedge clk);
        check(cyc);
        if (!rst_p) begin
            busy_now = (cyc >= busy_lo) && (cyc <= busy_hi);
            if (fs && busy_now) exp_ovr = 1'b1;
            else if (clr)       exp_ovr = 1'b0;
            if (fs && !busy_now) plan_frame(cyc, mk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        rd_cyc_q.delete(); wr_cyc_q.delete(); wr_ch_q.delete(); wr_code_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.fsync = 1'b0; bus.ch_en = '0; bus.clr_err = 1'b0;
        bus.pcm_in = '0; bus.enc_done = 1'b0; bus.enc_code = '0;
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        idle(3);

        // Two channels, 1-cycle datapath, fixed sample and code.
        fix_d = 1; fix_s = 8'hA5; fix_c = 9;
        clear_logs();
        tick(1'b1, 32'h0000_0005, 1'b0, 1'b0); f = cyc;
        idle(14);
        fix_d = 0; fix_s = -1; fix_c = -1;
        cmp("t1_nrd", 32'(rd_cyc_q.size()), 32'(2));
        if (rd_cyc_q.size() == 2) begin
            cmp("t1_rd0_ofs", 32'(rd_cyc_q[0] - f), 32'(1));
            cmp("t1_rd1_ofs", 32'(rd_cyc_q[1] - f), 32'(6));
        end
        cmp("t1_nwr", 32'(wr_cyc_q.size()), 32'(2));
        if (wr_cyc_q.size() == 2) begin
            cmp("t1_wr0_ofs", 32'(wr_cyc_q[0] - f), 32'(5));
            cmp("t1_wr1_ofs", 32'(wr_cyc_q[1] - f), 32'(10));
            cmp("t1_wr0_ch", 32'(wr_ch_q[0]), 32'(0));
            cmp("t1_wr1_ch", 32'(wr_ch_q[1]), 32'(2));
            cmp("t1_wr0_code", 32'(wr_code_q[0]), 32'(9));
            cmp("t1_wr1_code", 32'(wr_code_q[1]), 32'(9));
        end
        cmp("t1_busy_end", 32'(bus.busy), 32'(0));

        // An empty mask produces no activity.
        clear_logs();
        tick(1'b1, 32'h0, 1'b0, 1'b0);
        idle(10);
        cmp("t2_nrd", 32'(rd_cyc_q.size()), 32'(0));
        cmp("t2_busy", 32'(bus.busy), 32'(0));
        cmp("t2_ovr", 32'(bus.overrun), 32'(0));

        // Overrun: fsync during WAIT, clear, then a set and a clear in the same cycle.
        fix_d = 4;
        clear_logs();
        tick(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        idle(4);
        tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(1);
        cmp("t3_ovr_set", 32'(bus.overrun), 32'(1));
        idle(20);
        cmp("t3_nwr", 32'(wr_cyc_q.size()), 32'(2));
        cmp("t3_ovr_hold", 32'(bus.overrun), 32'(1));
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);
        cmp("t3_ovr_clr", 32'(bus.overrun), 32'(0));
        tick(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 32'h0000_0001, 1'b1, 1'b0);
        idle(1);
        cmp("t3_ovr_setwins", 32'(bus.overrun), 32'(1));
        idle(10);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);

        // All 32 channels, 3-cycle datapath.
        fix_d = 3;
        clear_logs();
        tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0); f = cyc;
        idle(230);
        cmp("t4_nwr", 32'(wr_cyc_q.size()), 32'(32));
        if (wr_cyc_q.size() == 32) begin
            for (int i = 0; i < 32; i++) cmp("t4_wr_ch", 32'(wr_ch_q[i]), 32'(i));
            cmp("t4_last_wr_ofs", 32'(wr_cyc_q[31] - f), 32'(224));
        end

        // Reset during WAIT of channel 1.
        fix_d = 4;
        clear_logs();
        tick(1'b1, 32'h0000_000B, 1'b0, 1'b0);
        idle(12);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        idle(12);
        cmp("t5_nwr", 32'(wr_cyc_q.size()), 32'(1));
        if (wr_cyc_q.size() == 1) cmp("t5_wr_ch", 32'(wr_ch_q[0]), 32'(0));
        fix_d = 0;
        clear_logs();
        tick(1'b1, 32'h0000_000B, 1'b0, 1'b0); f = cyc;
        idle(40);
        cmp("t5_restart_nwr", 32'(wr_cyc_q.size()), 32'(3));
        if (wr_cyc_q.size() == 3) cmp("t5_restart_ch", 32'(wr_ch_q[0]), 32'(0));
        if (rd_cyc_q.size() > 0) cmp("t5_restart_rd_ofs", 32'(rd_cyc_q[0] - f), 32'(1));
        else cmp("t5_restart_nrd", 32'(0), 32'(1));

        // Random traffic: fsync at any time, varied masks, stray enc_done, clears and occasional resets.
        spur_en = 1'b1;
        while (cyc < 4200) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0:       m = 32'h0;
                1:       m = 32'h1 << $urandom_range(0, 31);
                2:       m = $urandom & $urandom & $urandom;
                default: m = $urandom;
            endcase
            tick(r < 4, m, $urandom_range(0, 40) == 0, $urandom_range(0, 999) == 0);
        end
        spur_en = 1'b0;
        idle(300);
        cmp("drain_busy", 32'(bus.busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
